mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Iterative unsigned 32-bit multiply/divide unit. It sits directly downstream of the register file: it consumes the two read-port operands (BusA/BusB) plus a destination register index, computes over multiple cycles, and produces a write-back request (enable, register index, data) that feeds the register file's RegWr/RW/BusW write port. The multi-cycle controller starts it and stalls on `busy` until `done`.

## Interface
- `WIDTH`, 32, operand/result width.
- `REG_AW`, 4, register-index width, matching the 16-entry register file.
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request to begin an operation; sampled only in IDLE.
- `op`  in  2  operation select: 00 MUL (low word), 01 MULHU (high word), 10 DIVU (quotient), 11 REMU (remainder).
- `bus_a`  in  WIDTH  operand A (multiplicand/dividend), from register file BusA.
- `bus_b`  in  WIDTH  operand B (multiplier/divisor), from register file BusB.
- `rw_in`  in  REG_AW  destination register index for the result.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse; result valid.
- `wb_en`  out  1  write-back enable to register file (RegWr); pulses with `done` unless `wb_rw` == 0.
- `wb_rw`  out  REG_AW  captured destination index (RW).
- `wb_data`  out  WIDTH  result (BusW); held until the next `done`.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: on edge with `start`=1, latch `op`, `bus_a`, `bus_b`, `rw_in`; clear the 5-bit iteration counter.
  - If the op is DIVU/REMU and `bus_b`==0, go directly to DONE.
  - Otherwise, go to RUN.
- RUN: one radix-2 step per cycle; after step 31 (counter == 31), go to DONE.
- DONE: `done`=1, `wb_en`=1 (if `wb_rw`≠0); unconditional return to IDLE next edge.
- Multiply: unsigned shift-add into a 2·WIDTH accumulator.
  - Each step: if the current LSB of the multiplier is 1, add the multiplicand to the upper half, keeping the carry.
  - Then shift the accumulator right one bit.
  - MUL returns bits [31:0] of the 64-bit product; MULHU returns bits [63:32].
- Divide: unsigned restoring division.
  - Remainder register is WIDTH+1 bits.
  - Each step: shift {rem, quotient} left one bit; trial-subtract the divisor.
  - If the result is non-negative, keep it and set the quotient LSB to 1.
  - DIVU returns the quotient; REMU returns the remainder.
- Divide by zero: DIVU result 0xFFFFFFFF, REMU result = dividend.
- All arithmetic unsigned, modulo 2^WIDTH on outputs; no overflow flag.
- `start` asserted while `busy`: ignored, no queuing; inputs are not re-latched.
- Operand inputs may change freely after the accept edge; only latched copies are used.
- `wb_rw`==0: `done` still pulses, `wb_en` stays 0 (R0 is never written).
- Reset (asynchronous, any state including mid-RUN):
  - Next state is IDLE; operation abandoned, no `done`.
  - `busy`=0, `done`=0, `wb_en`=0, `wb_rw`=0, `wb_data`=0, counter=0.

## Timing
- Accept edge E0 (IDLE, `start`=1).
- Normal op: RUN during E1..E32 (32 steps); DONE entered at E32; `done`/`wb_en` high for cycle E32–E33; IDLE at E33. Earliest next accept is E34.
- Divide-by-zero: DONE entered at E0; `done` high for E0–E1; IDLE at E1.
- `busy` rises after E0 and falls at the edge leaving DONE.
- `wb_data`/`wb_rw` update when DONE is entered and are stable during the `done` cycle. They hold until the next DONE entry or reset.
- All outputs are registered or pure decodes of state; there is no combinational path from inputs to outputs.

## Test plan
- Reset then idle: `reset_n` low -> all outputs 0. Release with `start`=0 -> `busy` stays 0 indefinitely.
- MUL/MULHU: A=0xFFFFFFFF, B=0x00000002, rw=3.
  - MUL -> `wb_data`=0xFFFFFFFE, `wb_rw`=3, `wb_en` pulses 33 cycles after accept.
  - MULHU, same operands -> 0x00000001.
- DIVU/REMU: A=100, B=7, rw=5 -> DIVU 14, REMU 2, each `done` exactly 33 cycles after accept. A=0x12345678, B=1 -> quotient 0x12345678, remainder 0.
- Divide by zero: DIVU A=0x55, B=0 -> `done` 1 cycle after accept, `wb_data`=0xFFFFFFFF. REMU, same operands -> 0x00000055.
- Busy and R0 rules:
  - `start` held high with changing operands during RUN -> result reflects only the first accepted operands, and exactly one `done`.
  - rw=0 -> `done` pulses, `wb_en` stays 0.
- Reset mid-RUN: assert `reset_n` low at step 10 -> `busy` falls immediately and no `done` occurs. A fresh MUL 6×7 after release -> 42.

Source files
------------

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative unsigned 32-bit multiply/divide with register-file write-back.
module mul_div_unit #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [WIDTH-1:0]  bus_a,
  input  logic [WIDTH-1:0]  bus_b,
  input  logic [REG_AW-1:0] rw_in,
  output logic              busy,
  output logic              done,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_rw,
  output logic [WIDTH-1:0]  wb_data
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t r_state, w_next;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_a, r_b, r_rem, r_quo;
  logic [REG_AW-1:0]  r_rw;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc, w_acc_n;
  logic [WIDTH:0]     w_sum, w_rem_s, w_diff;
  logic [WIDTH-1:0]   w_rem_n, w_quo_n, w_res;
  logic               w_dbz;
  assign w_dbz = op[1] && bus_b == '0;
  always_comb begin
    w_next = r_state;
    if (r_state == S_IDLE)
      w_next = start ? (w_dbz ? S_DONE : S_RUN) : S_IDLE;
    else if (r_state == S_RUN)
      w_next = r_cnt == LAST ? S_DONE : S_RUN;
    else
      w_next = S_IDLE;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) r_state <= S_IDLE;
    else r_state <= w_next;
  // shift-add step: carry out of the upper-half add becomes the new MSB
  assign w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
  assign w_acc_n = {w_sum, r_acc[WIDTH-1:1]};
  // restoring step: remainder stays below the divisor, so WIDTH bits hold it between steps
  assign w_rem_s = {r_rem, r_quo[WIDTH-1]};
  assign w_diff  = w_rem_s - {1'b0, r_b};
  assign w_rem_n = w_diff[WIDTH] ? w_rem_s[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_quo_n = {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
  assign w_res   = r_op == 2'b00 ? w_acc_n[WIDTH-1:0] :
                   r_op == 2'b01 ? w_acc_n[2*WIDTH-1:WIDTH] :
                   r_op == 2'b10 ? w_quo_n : w_rem_n;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_rw    <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      wb_rw   <= '0;
      wb_data <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_op  <= op;
      r_a   <= bus_a;
      r_b   <= bus_b;
      r_rw  <= rw_in;
      r_cnt <= '0;
      r_acc <= {{WIDTH{1'b0}}, bus_b};
      r_rem <= '0;
      r_quo <= bus_a;
      if (w_dbz) begin
        wb_data <= op[0] ? bus_a : '1;
        wb_rw   <= rw_in;
      end
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt + 1'b1;
      r_acc <= w_acc_n;
      r_rem <= w_rem_n;
      r_quo <= w_quo_n;
      if (r_cnt == LAST) begin
        wb_data <= w_res;
        wb_rw   <= r_rw;
      end
    end
  end
  assign busy  = r_state != S_IDLE;
  assign done  = r_state == S_DONE;
  assign wb_en = done && wb_rw != '0;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: table vectors, random ops and corner sequences checked through a result scoreboard.
module tb_mul_div_unit;
  logic        clock = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [1:0]  op = '0;
  logic [31:0] bus_a = '0, bus_b = '0;
  logic [3:0]  rw_in = '0;
  logic        busy, done, wb_en;
  logic [3:0]  wb_rw;
  logic [31:0] wb_data;

  mul_div_unit dut (
    .clock(clock), .reset_n(reset_n), .start(start), .op(op),
    .bus_a(bus_a), .bus_b(bus_b), .rw_in(rw_in),
    .busy(busy), .done(done), .wb_en(wb_en), .wb_rw(wb_rw), .wb_data(wb_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [3:0]  rw;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  typedef struct {
    logic [31:0] data;
    logic [3:0]  rw;
    int          lat;
    int          acc;
  } sb_t;

  sb_t sb[$];
  int  cyc = 0, n_cmp = 0, n_bad = 0, done_cnt = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // latency is counted in rising edges from the accept edge to the edge that enters DONE
  always @(negedge clock) if (reset_n && done) begin
    sb_t e;
    done_cnt++;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
    end else begin
      e = sb.pop_front();
      chk("wb_data", wb_data, e.data);
      chk("wb_rw", 32'(wb_rw), 32'(e.rw));
      chk("wb_en", 32'(wb_en), 32'(e.rw != 0));
      chk("latency", 32'(cyc - e.acc), 32'(e.lat));
      chk("busy_in_done", 32'(busy), 32'd1);
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0 && !busy) return;
      @(negedge clock);
      #1;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL timeout: got busy=%0b pending=%0d expected idle", busy, sb.size());
    sb.delete();
  endtask

  task automatic run_op(logic [1:0] o, logic [31:0] a, logic [31:0] b, logic [3:0] rw,
                        logic [31:0] exp, int lat);
    op = o; bus_a = a; bus_b = b; rw_in = rw; start = 1'b1;
    sb.push_back('{data: exp, rw: rw, lat: lat, acc: cyc + 1});
    @(posedge clock);
    #1;
    start = 1'b0;
    bus_a = $urandom;
    bus_b = $urandom;
    rw_in = 4'($urandom);
    wait_idle();
    @(negedge clock);
    #1;
  endtask

  vec_t tbl[14];

  initial begin
    int base;
    tbl[0]  = '{2'b00, 32'hFFFFFFFF, 32'h2,        4'd3, 32'hFFFFFFFE, 32};
    tbl[1]  = '{2'b01, 32'hFFFFFFFF, 32'h2,        4'd3, 32'h00000001, 32};
    tbl[2]  = '{2'b10, 32'd100,      32'd7,        4'd5, 32'd14,       32};
    tbl[3]  = '{2'b11, 32'd100,      32'd7,        4'd5, 32'd2,        32};
    tbl[4]  = '{2'b10, 32'h12345678, 32'h1,        4'd6, 32'h12345678, 32};
    tbl[5]  = '{2'b11, 32'h12345678, 32'h1,        4'd6, 32'h0,        32};
    tbl[6]  = '{2'b10, 32'h55,       32'h0,        4'd8, 32'hFFFFFFFF, 0};
    tbl[7]  = '{2'b11, 32'h55,       32'h0,        4'd8, 32'h00000055, 0};
    tbl[8]  = '{2'b00, 32'd9,        32'd9,        4'd0, 32'd81,       32};
    tbl[9]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd9, 32'hFFFFFFFE, 32};
    tbl[10] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd9, 32'h00000001, 32};
    tbl[11] = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd1, 32'h1,        32};
    tbl[12] = '{2'b10, 32'h80000000, 32'd3,        4'd2, 32'h2AAAAAAA, 32};
    tbl[13] = '{2'b11, 32'h80000000, 32'd3,        4'd2, 32'd2,        32};

    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_wb_en", 32'(wb_en), 0);
    chk("rst_wb_rw", 32'(wb_rw), 0);
    chk("rst_wb_data", wb_data, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (20) @(negedge clock);
    #1;
    chk("idle_busy", 32'(busy), 0);
    chk("idle_done_cnt", 32'(done_cnt), 0);

    foreach (tbl[i]) run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].rw, tbl[i].exp, tbl[i].lat);

    for (int i = 0; i < 8; i++) begin
      logic [1:0]  o;
      logic [31:0] a, b, r;
      logic [63:0] p;
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      p = {32'h0, a} * {32'h0, b};
      r = o == 2'b00 ? p[31:0] : o == 2'b01 ? p[63:32] :
          b == 0 ? (o[0] ? a : 32'hFFFFFFFF) : (o[0] ? a % b : a / b);
      run_op(o, a, b, 4'($urandom_range(1, 15)), r, (o[1] && b == 0) ? 0 : 32);
    end

    // start held high with churning operands: only the first accept counts
    base = done_cnt;
    op = 2'b00; bus_a = 32'd6; bus_b = 32'd7; rw_in = 4'd2; start = 1'b1;
    sb.push_back('{data: 32'd42, rw: 4'd2, lat: 32, acc: cyc + 1});
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      #1;
      if (done_cnt != base) break;
      op = 2'($urandom); bus_a = $urandom; bus_b = $urandom; rw_in = 4'($urandom);
    end
    start = 1'b0;
    repeat (5) @(negedge clock);
    #1;
    chk("hold_start_done_cnt", 32'(done_cnt - base), 1);
    wait_idle();

    // reset in the middle of RUN abandons the op
    base = done_cnt;
    op = 2'b00; bus_a = 32'd3; bus_b = 32'd5; rw_in = 4'd4; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    chk("run_busy", 32'(busy), 1);
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_wb_en", 32'(wb_en), 0);
    chk("midrst_wb_rw", 32'(wb_rw), 0);
    chk("midrst_wb_data", wb_data, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (40) @(negedge clock);
    #1;
    chk("midrst_no_done", 32'(done_cnt - base), 0);
    chk("midrst_idle", 32'(busy), 0);
    run_op(2'b00, 32'd6, 32'd7, 4'd7, 32'd42, 32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected completion");
    $fatal(1);
  end
endmodule
